four_bit_magnitude_comparator: RTL and testbench
================================================

// Module: four_bit_magnitude_comparator
// PURPOSE
//   Registered unsigned magnitude comparator for two 4-bit operands A and B.
//   Drives exactly one of three one-hot flags each cycle: less (A<B), equal (A==B), greater (A>B).
//   Sits as a leaf compare stage in datapath/control logic. Flags are registered for clean timing.
//   Single clock domain: one clock, synchronous active-high reset.
// PARAMETERS
//   WIDTH   4   operand width in bits; must be >= 1; operands are unsigned
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous reset, active-high
//   A        in   WIDTH  operand A, unsigned
//   B        in   WIDTH  operand B, unsigned
//   less     out  1      registered flag, 1 when A < B
//   equal    out  1      registered flag, 1 when A == B
//   greater  out  1      registered flag, 1 when A > B
// BEHAVIOUR
//   - Reset: on a rising clk edge with rst=1, less=0, equal=0 and greater=0.
//     While rst is held, all three flags stay 0. rst overrides any operand value.
//   - Latency: one cycle. A and B are sampled on rising edge N (with rst=0).
//     The flags reflect that sample from edge N until edge N+1. There is no combinational path from A/B to the outputs.
//   - Comparison is unsigned over the full WIDTH bits.
//     Example: 4'b1100 (12) is greater than 4'b0001 (1); it is not treated as a negative number.
//   - Invariant: on any edge with rst=0, exactly one of {less, equal, greater} is 1 (one-hot).
//     The all-zero state occurs only as a consequence of reset.
//   - Evaluation order is MSB-first, 7485-style:
//     - The first bit position (from MSB) where A and B differ decides the result.
//     - If A[i]=1 and B[i]=0 there, the result is greater; if A[i]=0 and B[i]=1, the result is less.
//     - If no bit differs, the result is equal.
//   - Boundaries:
//     - A=B=0 -> equal.
//     - A=B=all-ones -> equal.
//     - A=0, B=all-ones -> less.
//     - A=all-ones, B=0 -> greater.
//   - Back-to-back operand changes every cycle produce one result per cycle, with no bubbles and no hold state.
//   - Reset deasserted: the first edge with rst=0 loads the compare of the A/B present at that edge.
//   - X/Z on operands is undefined; the bench drives known values only.
// STRUCTURE
//   - Shared package: none required. Optionally export a 3-bit result encoding
//     {LESS=3'b100, EQUAL=3'b010, GREATER=3'b001} as localparams if other blocks consume the flags as a vector.
//   - Sub-module bit_compare_cell, one instance per bit, chained from MSB to LSB.
//     - Inputs: a_i, b_i, plus cascade inputs gt_in, eq_in, lt_in from the more-significant cell.
//     - Outputs: gt_out, eq_out, lt_out.
//     - If eq_in=1, the cell resolves on its own bit; otherwise it passes the cascade inputs through.
//     - The MSB cell's cascade is tied to eq_in=1, gt_in=0, lt_in=0.
//   - The top level instantiates WIDTH cells with a generate loop and registers the LSB cell's outputs into less/equal/greater.
// TESTING
//   1. rst=1 for 2 edges with A=4'b0101, B=4'b0100 -> less=0, equal=0, greater=0 throughout.
//   2. rst=0, A=4'b0000, B=4'b0000 -> after 1 edge: equal=1, less=0, greater=0.
//   3. A=4'b0001, B=4'b0100 -> after 1 edge: less=1; then A=4'b0011, B=4'b0100 -> less=1.
//   4. A=4'b0101, B=4'b0100 (LSB decides) -> after 1 edge: greater=1, others 0.
//   5. A=4'b0001, B=4'b1100 (unsigned MSB case) -> less=1; then A=4'b1111, B=4'b0000 -> greater=1.
//   6. Exhaustive 256 pairs, one per cycle, versus a reference model -> one-cycle-delayed flags match and stay one-hot.
//      Then assert rst mid-sequence -> all flags 0 on the next edge.

Source files
------------

// File: rtl/four_bit_magnitude_comparator_pkg.sv
// Shared types and encodings for the magnitude comparator.
// Result vector layout matches {less, equal, greater}.
package four_bit_magnitude_comparator_pkg;

  localparam int CMP_WIDTH = 4;

  localparam logic [2:0] RES_LESS    = 3'b100;
  localparam logic [2:0] RES_EQUAL   = 3'b010;
  localparam logic [2:0] RES_GREATER = 3'b001;
  localparam logic [2:0] RES_NONE    = 3'b000;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cascade_t;

  localparam cascade_t CASCADE_SEED = '{
    gt: 1'b0,
    eq: 1'b1,
    lt: 1'b0
  };

  function automatic logic [2:0] to_result(
    input cascade_t c
  );
    return {c.lt, c.eq, c.gt};
  endfunction

endpackage

// File: rtl/four_bit_magnitude_comparator_bit_compare_cell.sv
// One bit of the MSB-first compare cascade.
// Resolves on its own bit only while higher bits are still equal.
module bit_compare_cell
  import four_bit_magnitude_comparator_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic gt_in,
  input  logic eq_in,
  input  logic lt_in,
  output logic gt_out,
  output logic eq_out,
  output logic lt_out
);

  cascade_t res;

  always_comb begin
    res = '{gt: gt_in, eq: eq_in, lt: lt_in};
    if (eq_in) begin
      unique case (1'b1)
        (a_i & ~b_i): res = '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
        (~a_i & b_i): res = '{gt: 1'b0, eq: 1'b0, lt: 1'b1};
        default:      res = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
      endcase
    end
  end

  assign gt_out = res.gt;
  assign eq_out = res.eq;
  assign lt_out = res.lt;

endmodule

// File: rtl/four_bit_magnitude_comparator.sv
// Registered unsigned magnitude comparator.
// Cascade of per-bit cells, LSB cell result registered into one-hot flags.
module four_bit_magnitude_comparator
  import four_bit_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  cascade_t res;

  // Each stage owns its wires; stage i reads stage i+1 (more significant).
  for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_cell
    logic gt_c;
    logic eq_c;
    logic lt_c;
    logic gt_p;
    logic eq_p;
    logic lt_p;

    if (i == WIDTH - 1) begin : g_seed
      assign gt_p = CASCADE_SEED.gt;
      assign eq_p = CASCADE_SEED.eq;
      assign lt_p = CASCADE_SEED.lt;
    end else begin : g_link
      assign gt_p = g_cell[i+1].gt_c;
      assign eq_p = g_cell[i+1].eq_c;
      assign lt_p = g_cell[i+1].lt_c;
    end

    bit_compare_cell u_cell (
      .a_i    (A[i]),
      .b_i    (B[i]),
      .gt_in  (gt_p),
      .eq_in  (eq_p),
      .lt_in  (lt_p),
      .gt_out (gt_c),
      .eq_out (eq_c),
      .lt_out (lt_c)
    );
  end

  assign res = '{
    gt: g_cell[0].gt_c,
    eq: g_cell[0].eq_c,
    lt: g_cell[0].lt_c
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      {less, equal, greater} <= RES_NONE;
    end else begin
      {less, equal, greater} <= to_result(res);
    end
  end

endmodule

// File: tb/tb_four_bit_magnitude_comparator.sv
// Self-checking bench for the registered magnitude comparator.
// Reference model uses plain integer compares.
module tb_four_bit_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       less;
  logic       equal;
  logic       greater;

  int checks = 0;
  int failures = 0;

  four_bit_magnitude_comparator dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .less    (less),
    .equal   (equal),
    .greater (greater)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model(input int a, input int b);
    if (a < b)  return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  task automatic drive(input logic r, input int a, input int b);
    rst = r;
    A = a[3:0];
    B = b[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 5, 4);
      checks++;
      if ({less, equal, greater} !== 3'b000) begin
        failures++;
        $display("FAIL reset_%0d got=%b want=000",
                 k, {less, equal, greater});
      end
    end
  endtask

  task automatic test_directed();
    int ta [8] = '{0, 1, 3, 5, 1, 15, 15, 0};
    int tb [8] = '{0, 4, 4, 4, 12, 0, 15, 15};
    logic [2:0] want;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, ta[k], tb[k]);
      want = model(ta[k], tb[k]);
      checks++;
      if ({less, equal, greater} !== want) begin
        failures++;
        $display("FAIL directed a=%0d b=%0d got=%b want=%b",
                 ta[k], tb[k], {less, equal, greater}, want);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [2:0] want;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive(1'b0, a, b);
        want = model(a, b);
        checks++;
        if ({less, equal, greater} !== want ||
            !$onehot({less, equal, greater})) begin
          failures++;
          $display("FAIL exhaustive a=%0d b=%0d got=%b want=%b",
                   a, b, {less, equal, greater}, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 15, 0);
    checks++;
    if ({less, equal, greater} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid got=%b want=000",
               {less, equal, greater});
    end
    drive(1'b0, 2, 9);
    checks++;
    if ({less, equal, greater} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release got=%b want=100",
               {less, equal, greater});
    end
  endtask

  task automatic test_back_to_back();
    int a;
    int b;
    logic [2:0] want;
    for (int k = 0; k < 300; k++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      drive(1'b0, a, b);
      want = model(a, b);
      checks++;
      if ({less, equal, greater} !== want) begin
        failures++;
        $display("FAIL random a=%0d b=%0d got=%b want=%b",
                 a, b, {less, equal, greater}, want);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    A = 4'd0;
    B = 4'd0;
    #2;
    test_reset();
    test_directed();
    test_exhaustive();
    test_reset_mid();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
